spi_cmd_frame_assembler: RTL and testbench

Upstream stage of the register table in the FPGA main-control block. Consumes the byte stream delivered by the SPI slave receiver and assembles each command frame: one address byte, plus three data bytes for write commands. Emits a single-cycle `reg_input_valid` strobe with `reg_addr`/`reg_data` to the register table. Malformed, aborted or stalled frames are discarded and flagged.

---
 rtl/spi_cmd_frame_assembler.sv | 153 +++++++++++++++
 tb/tb_spi_cmd_frame_assembler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_frame_assembler.sv
// Assembles SPI command frames (address byte plus optional 3 data bytes)
// into single-cycle register-table writes; bad or stalled frames are dropped.
module spi_cmd_frame_assembler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMO_W          = 13
) (
    input  logic        sysClk,
    input  logic        sysRst,
    input  logic        spi_cs_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    output logic [7:0]  reg_addr,
    output logic [16:0] reg_data,
    output logic        reg_input_valid,
    output logic        frame_busy,
    output logic        frame_error,
    output logic [7:0]  error_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA0,
        S_DATA1,
        S_DATA2,
        S_EMIT
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [16:0] data_q, data_d;
    logic [TMO_W-1:0] gap_q, gap_d;
    logic [7:0]  out_addr_q, out_addr_d;
    logic [16:0] out_data_q, out_data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic accept;
    logic in_data;
    logic abort;

    assign accept  = rx_byte_valid & ~spi_cs_n;
    assign in_data = (state_q == S_DATA0) || (state_q == S_DATA1) ||
                     (state_q == S_DATA2);
    // A byte landing on the timeout cycle keeps the frame alive
    assign abort   = in_data &
                     (spi_cs_n | ((gap_q == TMO_LIM) & ~accept));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        gap_d      = '0;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        cnt_d      = cnt_q;

        if (abort) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_EMIT: begin
                    if (state_q == S_EMIT) begin
                        out_addr_d = addr_q;
                        out_data_d = data_q;
                        valid_d    = 1'b1;
                        state_d    = S_IDLE;
                    end
                    if (accept) begin
                        addr_d = rx_byte;
                        if (rx_byte[7]) begin
                            state_d = S_DATA0;
                        end else begin
                            data_d  = '0;
                            state_d = S_EMIT;
                        end
                    end
                end
                S_DATA0: begin
                    if (accept) begin
                        data_d[7:0] = rx_byte;
                        state_d     = S_DATA1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                S_DATA1: begin
                    if (accept) begin
                        data_d[15:8] = rx_byte;
                        state_d      = S_DATA2;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                S_DATA2: begin
                    if (accept) begin
                        if (rx_byte[7:1] != 7'd0) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            data_d[16] = rx_byte[0];
                            state_d    = S_EMIT;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (err_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            gap_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            gap_q      <= gap_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign reg_addr        = out_addr_q;
    assign reg_data        = out_data_q;
    assign reg_input_valid = valid_q;
    assign frame_busy      = in_data;
    assign frame_error     = err_q;
    assign error_count     = cnt_q;

endmodule

// File: tb/tb_spi_cmd_frame_assembler.sv
// Scoreboard bench for spi_cmd_frame_assembler: directed frames push
// expected strobes/errors; a negedge monitor pops and compares them.
module tb_spi_cmd_frame_assembler;

    logic        clk = 1'b0;
    logic        sysRst;
    logic        spi_cs_n;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [7:0]  reg_addr;
    logic [16:0] reg_data;
    logic        reg_input_valid;
    logic        frame_busy;
    logic        frame_error;
    logic [7:0]  error_count;

    always #5 clk = ~clk;

    spi_cmd_frame_assembler #(
        .TIMEOUT_CYCLES(16),
        .TMO_W(5)
    ) dut (
        .sysClk(clk),
        .sysRst(sysRst),
        .spi_cs_n(spi_cs_n),
        .rx_byte(rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .reg_addr(reg_addr),
        .reg_data(reg_data),
        .reg_input_valid(reg_input_valid),
        .frame_busy(frame_busy),
        .frame_error(frame_error),
        .error_count(error_count)
    );

    typedef struct {
        bit          is_err;
        logic [7:0]  a;
        logic [16:0] d;
        logic [7:0]  cnt;
        int          at;
    } ev_t;

    ev_t sbq[$];
    ev_t e;
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    int  exp_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (reg_input_valid && frame_error) begin
            chk("strobe_error_overlap", {31'd0, frame_error}, 32'd0);
        end else if (reg_input_valid || frame_error) begin
            if (sbq.size() == 0) begin
                chk("unexpected_event",
                    {30'd0, reg_input_valid, frame_error}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("event_kind", {31'd0, frame_error}, {31'd0, e.is_err});
                if (!e.is_err) begin
                    chk("reg_addr", {24'd0, reg_addr}, {24'd0, e.a});
                    chk("reg_data", {15'd0, reg_data}, {15'd0, e.d});
                    chk("strobe_latency", cyc, e.at);
                end else begin
                    chk("error_count", {24'd0, error_count}, {24'd0, e.cnt});
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        tick();
        rx_byte_valid = 1'b0;
    endtask

    task automatic exp_strobe(input logic [7:0] a, input logic [16:0] d);
        sbq.push_back('{1'b0, a, d, 8'h00, cyc + 2});
    endtask

    task automatic exp_error;
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        sbq.push_back('{1'b1, 8'h00, 17'h0, exp_err[7:0], -1});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"},  {24'd0, reg_addr}, 32'd0);
        chk({tag, "_data"},  {15'd0, reg_data}, 32'd0);
        chk({tag, "_valid"}, {31'd0, reg_input_valid}, 32'd0);
        chk({tag, "_busy"},  {31'd0, frame_busy}, 32'd0);
        chk({tag, "_error"}, {31'd0, frame_error}, 32'd0);
        chk({tag, "_count"}, {24'd0, error_count}, 32'd0);
    endtask

    initial begin
        sysRst        = 1'b1;
        spi_cs_n      = 1'b1;
        rx_byte       = 8'h00;
        rx_byte_valid = 1'b0;
        idle(3);
        chk_zero("reset");
        sysRst   = 1'b0;
        spi_cs_n = 1'b0;
        idle(2);

        // read frame
        exp_strobe(8'h08, 17'h0);
        send(8'h08);
        idle(3);

        // write frame
        send(8'h87);
        chk("busy_after_b0", {31'd0, frame_busy}, 32'd1);
        send(8'h34);
        send(8'h12);
        chk("busy_before_b3", {31'd0, frame_busy}, 32'd1);
        exp_strobe(8'h87, 17'h11234);
        send(8'h01);
        chk("busy_in_emit", {31'd0, frame_busy}, 32'd0);
        idle(3);
        chk("held_addr", {24'd0, reg_addr}, 32'h87);
        chk("held_data", {15'd0, reg_data}, 32'h11234);

        // bad D2
        send(8'h8A);
        send(8'h00);
        send(8'h00);
        exp_error();
        send(8'h02);
        idle(3);
        chk("bad_d2_busy", {31'd0, frame_busy}, 32'd0);
        chk("bad_d2_addr", {24'd0, reg_addr}, 32'h87);
        chk("bad_d2_data", {15'd0, reg_data}, 32'h11234);

        // CS abort then read
        send(8'h87);
        send(8'h01);
        exp_error();
        spi_cs_n = 1'b1;
        tick();
        spi_cs_n = 1'b0;
        idle(2);
        exp_strobe(8'h09, 17'h0);
        send(8'h09);
        idle(3);

        // timeout after 16 idle cycles
        send(8'h87);
        exp_error();
        idle(20);
        // second byte after 15 idle cycles
        send(8'h87);
        idle(15);
        send(8'h00);
        send(8'h00);
        exp_strobe(8'h87, 17'h0);
        send(8'h00);
        idle(3);
        // byte landing on the timeout cycle wins
        send(8'h87);
        idle(16);
        send(8'h05);
        send(8'h00);
        exp_strobe(8'h87, 17'h5);
        send(8'h00);
        idle(3);

        // back-to-back reads, second byte lands in EMIT
        exp_strobe(8'h10, 17'h0);
        send(8'h10);
        exp_strobe(8'h11, 17'h0);
        send(8'h11);
        idle(3);

        // CS high together with a byte in DATA1
        send(8'h87);
        send(8'h01);
        exp_error();
        spi_cs_n      = 1'b1;
        rx_byte       = 8'h55;
        rx_byte_valid = 1'b1;
        tick();
        rx_byte_valid = 1'b0;
        spi_cs_n      = 1'b0;
        idle(2);
        exp_strobe(8'h0C, 17'h0);
        send(8'h0C);
        idle(3);

        // bad D2 together with CS rising
        send(8'h8A);
        send(8'h00);
        send(8'h00);
        exp_error();
        spi_cs_n      = 1'b1;
        rx_byte       = 8'h02;
        rx_byte_valid = 1'b1;
        tick();
        rx_byte_valid = 1'b0;
        spi_cs_n      = 1'b0;
        idle(3);

        // bytes with CS high in IDLE are ignored
        spi_cs_n = 1'b1;
        send(8'h05);
        idle(2);
        spi_cs_n = 1'b0;
        chk("cs_high_idle_busy", {31'd0, frame_busy}, 32'd0);
        idle(2);

        // saturation
        repeat (260) begin
            send(8'h87);
            exp_error();
            spi_cs_n = 1'b1;
            tick();
            spi_cs_n = 1'b0;
        end
        idle(3);
        chk("saturated_count", {24'd0, error_count}, 32'd255);

        // reset mid-frame
        send(8'h87);
        send(8'h01);
        sysRst = 1'b1;
        tick();
        chk_zero("midreset");
        tick();
        sysRst = 1'b0;
        idle(5);
        chk_zero("post_reset");
        chk("scoreboard_drained", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
